bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 91 +++++++++
 tb/tb_bin2bcd_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and BCD sizing constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_MAX    = 9999;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    // One extra scratch digit holds ten-thousands for 14-bit inputs.
    localparam int SCR_DIGITS = NUM_DIGITS + 1;
    localparam int SCR_W      = SCR_DIGITS * DIGIT_W;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per SHIFT cycle.
// Optional macro BIN2BCD_SAT_EN clamps inputs above 9999 and flags ovf.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SCR_W-1:0]   scr;
    logic [SCR_W-1:0]   scr_cor;
    logic [BIN_W-1:0]   sr;
    logic               ovf_pend;
    logic [BIN_W-1:0]   cap_val;
    logic               cap_ovf;
    logic [SCR_W+BIN_W-1:0] cat_n;

`ifdef BIN2BCD_SAT_EN
    logic [15:0] bin_ext;
    assign bin_ext = 16'(bin_in);
    assign cap_ovf = bin_ext > 16'(BCD_MAX);
    assign cap_val = cap_ovf ? BIN_W'(BCD_MAX) : bin_in;
`else
    assign cap_ovf = 1'b0;
    assign cap_val = bin_in;
`endif

    for (genvar i = 0; i < SCR_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr[i*DIGIT_W +: DIGIT_W]),
            .dout (scr_cor[i*DIGIT_W +: DIGIT_W])
        );
    end

    assign cat_n = {scr_cor, sr} << 1;
    assign busy  = (state != IDLE);

    // Main FSM: capture, shift BIN_W times, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            scr      <= '0;
            sr       <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= 16'h0000;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= cap_val;
                        scr      <= '0;
                        cnt      <= '0;
                        ovf_pend <= cap_ovf;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr <= cat_n[SCR_W+BIN_W-1:BIN_W];
                    sr  <= cat_n[BIN_W-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_out <= scr[15:0];
                    ovf     <= ovf_pend;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq with an expected-result queue.
// Honours BIN2BCD_SAT_EN the same way the design does.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;
    localparam int TMO   = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    logic [16:0] q[$];

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int v);
        int   x = v;
        logic o = 1'b0;
`ifdef BIN2BCD_SAT_EN
        if (x > 9999) begin
            x = 9999;
            o = 1'b1;
        end
`endif
        return {o, 4'((x / 1000) % 10), 4'((x / 100) % 10),
                4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic [16:0] pop_exp();
        if (q.size() == 0) return 17'h1ffff;
        return q.pop_front();
    endfunction

    // Launch one conversion and wait for done; no checking here.
    task automatic run_conv(input int v, output logic [16:0] got,
                            output int lat, output int bsy);
        @(negedge clk);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        q.push_back(model(v));
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        lat = 0;
        bsy = 0;
        while (done !== 1'b1 && lat < TMO) begin
            if (busy === 1'b1) bsy++;
            @(negedge clk);
            lat++;
        end
        got = {ovf, bcd_out};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bin_in = '0;
        #1;
        checks++;
        if ({busy, done, ovf, bcd_out} !== 19'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b ovf=%b bcd=%h want 0",
                     busy, done, ovf, bcd_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [16:0] got, e;
        int lat, bsy;
        run_conv(0, got, lat, bsy);
        e = pop_exp();
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL zero_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL zero_result got %h want %h", got, e);
        end
    endtask

    task automatic test_1234();
        logic [16:0] got, e;
        int lat, bsy;
        run_conv(1234, got, lat, bsy);
        e = pop_exp();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL r1234_result got %h want %h", got, e);
        end
        checks++;
        if (bsy !== LAT) begin
            errors++;
            $display("FAIL r1234_busy got %0d want %0d", bsy, LAT);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL r1234_done_width got %b want 0", done);
        end
        checks++;
        if (bcd_out !== e[15:0]) begin
            errors++;
            $display("FAIL r1234_hold got %h want %h", bcd_out, e[15:0]);
        end
    endtask

    task automatic test_ignore_start();
        logic [16:0] got, e;
        int lat, bsy, extra;
        @(negedge clk);
        bin_in = BIN_W'(9999);
        start  = 1'b1;
        q.push_back(model(9999));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin_in = BIN_W'(5);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        got = {ovf, bcd_out};
        e = pop_exp();
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL ignore_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ignore_result got %h want %h", got, e);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_no_second got %0d active cycles want 0", extra);
        end
        run_conv(5, got, lat, bsy);
        e = pop_exp();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ignore_then5 got %h want %h", got, e);
        end
    endtask

    task automatic test_values();
        int vals[8] = '{12000, 9, 10, 99, 1000, 9999, 10000, 16383};
        logic [16:0] got, e;
        int lat, bsy;
        foreach (vals[i]) begin
            run_conv(vals[i], got, lat, bsy);
            e = pop_exp();
            checks++;
            if (got !== e || lat !== LAT) begin
                errors++;
                $display("FAIL value_%0d got %h lat %0d want %h lat %0d",
                         vals[i], got, lat, e, LAT);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [16:0] got, e;
        int lat, bsy, seen;
        @(negedge clk);
        bin_in = BIN_W'(4321);
        start  = 1'b1;
        q.push_back(model(4321));
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        q.delete();
        checks++;
        if ({busy, done, ovf, bcd_out} !== 19'h0) begin
            errors++;
            $display("FAIL abort_outputs got busy=%b done=%b ovf=%b bcd=%h want 0",
                     busy, done, ovf, bcd_out);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", seen);
        end
        run_conv(42, got, lat, bsy);
        e = pop_exp();
        checks++;
        if (got !== e || lat !== LAT) begin
            errors++;
            $display("FAIL abort_then42 got %h lat %0d want %h lat %0d",
                     got, lat, e, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        logic [16:0] r1, r2;
        int t, t1, t2;
        @(negedge clk);
        bin_in = BIN_W'(1);
        start  = 1'b1;
        q.push_back(model(1));
        @(negedge clk);
        bin_in = BIN_W'(10);
        q.push_back(model(10));
        t = 0;
        t1 = -1;
        t2 = -1;
        r1 = '0;
        r2 = '0;
        while (t2 < 0 && t < 3 * TMO) begin
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = t;
                    r1 = {ovf, bcd_out};
                end else begin
                    t2 = t;
                    r2 = {ovf, bcd_out};
                end
            end
            @(negedge clk);
            if (t1 >= 0) start = 1'b0;
            t++;
        end
        e = pop_exp();
        checks++;
        if (r1 !== e || t1 !== LAT) begin
            errors++;
            $display("FAIL b2b_first got %h at %0d want %h at %0d", r1, t1, e, LAT);
        end
        e = pop_exp();
        checks++;
        if (r2 !== e) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", r2, e);
        end
        checks++;
        if (t2 - t1 !== LAT + 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", t2 - t1, LAT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_1234();
        test_ignore_start();
        test_values();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
